mem_bus_arbiter: RTL and testbench

- Shares the single tagged memory bus between the instruction cache (loads only) and the data cache (loads and stores).
- Each cycle it grants one requester and forwards that requester's command, address and data to memory. The memory response goes back only to the granted requester.
- Records which requester owns each outstanding load tag, so returning tag/data beats reach only the owner.
- Sits between the icache/dcache and the memory model; both caches see the same bus semantics as a private memory port.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_tag_owner_table.sv | 52 +++++
 rtl/mem_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter and its tag owner table.
// Defaults `XLEN to 64 when the build does not supply it.
`ifndef XLEN
`define XLEN 64
`endif

package mem_arb_pkg;
   localparam int TAG_BITS = 4;
   localparam logic [TAG_BITS-1:0] NO_TAG = 4'd0;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_LOCK_I = 2'd1,
      ARB_LOCK_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_ICACHE = 1'b0,
      REQ_DCACHE = 1'b1
   } requester_t;
endpackage

// File: rtl/mem_tag_owner_table.sv
// Tracks which requester owns each outstanding load tag.
// A return clears its entry; a same-cycle set of the same tag takes precedence.
module mem_tag_owner_table
   import mem_arb_pkg::*;
#(
   parameter int NUM_TAGS = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                set_en,
   input  logic [TAG_BITS-1:0] set_tag,
   input  requester_t          set_owner,
   input  logic [TAG_BITS-1:0] ret_tag,
   output logic                ret_hit,
   output requester_t          ret_owner,
   output logic                orphan
);

   logic [NUM_TAGS-1:0] valid_r;
   logic [NUM_TAGS-1:0] owner_r;

   // Lookup of the returning tag against the current (pre-update) table
   always_comb begin
      ret_hit   = 1'b0;
      ret_owner = REQ_ICACHE;
      orphan    = 1'b0;
      if (ret_tag != NO_TAG) begin
         ret_hit   = valid_r[ret_tag];
         ret_owner = requester_t'(owner_r[ret_tag]);
         orphan    = ~valid_r[ret_tag];
      end else begin
         ret_hit = 1'b0;
      end
   end

   // Table update: clear on return first, so a new accept of the same tag survives
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_r <= {NUM_TAGS{1'b0}};
         owner_r <= {NUM_TAGS{1'b0}};
      end else begin
         if (ret_tag != NO_TAG) begin
            valid_r[ret_tag] <= 1'b0;
         end
         if (set_en) begin
            valid_r[set_tag] <= 1'b1;
            owner_r[set_tag] <= set_owner;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one tagged memory bus between icache and dcache with starvation guard and refusal lock.
// Optional statistics counters are enabled with `define MEM_ARB_STATS_EN.
`ifndef XLEN
`define XLEN 64
`endif

module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_TAGS   = 16,
   parameter int STARVE_MAX = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          icache_command,
   input  logic [`XLEN-1:0]    icache_addr,
   input  logic [1:0]          dcache_command,
   input  logic [`XLEN-1:0]    dcache_addr,
   input  logic [63:0]         dcache_data,
   output logic [TAG_BITS-1:0] icache_response,
   output logic [TAG_BITS-1:0] dcache_response,
   output logic [TAG_BITS-1:0] icache_tag,
   output logic [TAG_BITS-1:0] dcache_tag,
   output logic [63:0]         mem_data_out,
   output logic [1:0]          proc2mem_command,
   output logic [`XLEN-1:0]    proc2mem_addr,
   output logic [63:0]         proc2mem_data,
   input  logic [TAG_BITS-1:0] mem2proc_response,
   input  logic [63:0]         mem2proc_data,
   input  logic [TAG_BITS-1:0] mem2proc_tag,
   output logic                orphan_tag
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]         icache_grant_cnt,
   output logic [31:0]         dcache_grant_cnt,
   output logic [31:0]         lock_cycle_cnt
`endif
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   arb_state_t       state_r, state_nxt_s;
   logic [CNT_W-1:0] starve_r, starve_nxt_s;
   logic             ic_req_s, dc_req_s;
   logic             idle_valid_s, grant_valid_s;
   requester_t       idle_owner_s, grant_owner_s;
   logic             accepted_s, set_en_s, ret_hit_s, orphan_s;
   requester_t       ret_owner_s;

   assign ic_req_s = (icache_command != BUS_NONE);
   assign dc_req_s = (dcache_command != BUS_NONE);

   // Grant selection and next state; a lock only holds while its owner keeps requesting
   always_comb begin
      idle_valid_s  = ic_req_s | dc_req_s;
      idle_owner_s  = REQ_ICACHE;
      if (ic_req_s && (starve_r == STARVE_LIM)) begin
         idle_owner_s = REQ_ICACHE;
      end else if (dc_req_s) begin
         idle_owner_s = REQ_DCACHE;
      end else begin
         idle_owner_s = REQ_ICACHE;
      end
      grant_valid_s = idle_valid_s;
      grant_owner_s = idle_owner_s;
      case (state_r)
         ARB_LOCK_I: if (ic_req_s) begin
                        grant_valid_s = 1'b1;
                        grant_owner_s = REQ_ICACHE;
                     end else begin
                        grant_owner_s = idle_owner_s;
                     end
         ARB_LOCK_D: if (dc_req_s) begin
                        grant_valid_s = 1'b1;
                        grant_owner_s = REQ_DCACHE;
                     end else begin
                        grant_owner_s = idle_owner_s;
                     end
         ARB_IDLE:   grant_owner_s = idle_owner_s;
         default:    grant_owner_s = idle_owner_s;
      endcase
      state_nxt_s = ARB_IDLE;
      if (grant_valid_s && (mem2proc_response == NO_TAG)) begin
         state_nxt_s = (grant_owner_s == REQ_ICACHE) ? ARB_LOCK_I : ARB_LOCK_D;
      end else begin
         state_nxt_s = ARB_IDLE;
      end
   end

   // Forward the granted command and route the memory response back to it
   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = {`XLEN{1'b0}};
      proc2mem_data    = 64'd0;
      icache_response  = NO_TAG;
      dcache_response  = NO_TAG;
      if (grant_valid_s && (grant_owner_s == REQ_DCACHE)) begin
         proc2mem_command = dcache_command;
         proc2mem_addr    = dcache_addr;
         proc2mem_data    = dcache_data;
         dcache_response  = mem2proc_response;
      end else if (grant_valid_s) begin
         proc2mem_command = icache_command;
         proc2mem_addr    = icache_addr;
         icache_response  = mem2proc_response;
      end else begin
         proc2mem_command = BUS_NONE;
      end
      accepted_s   = grant_valid_s && (mem2proc_response != NO_TAG);
      set_en_s     = accepted_s && (proc2mem_command == BUS_LOAD);
      starve_nxt_s = starve_r;
      if (!ic_req_s || (grant_valid_s && (grant_owner_s == REQ_ICACHE))) begin
         starve_nxt_s = {CNT_W{1'b0}};
      end else if (starve_r != STARVE_LIM) begin
         starve_nxt_s = starve_r + CNT_W'(1'b1);
      end else begin
         starve_nxt_s = starve_r;
      end
   end

   // State and starvation counter registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r  <= ARB_IDLE;
         starve_r <= {CNT_W{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         starve_r <= starve_nxt_s;
      end
   end

   mem_tag_owner_table #(.NUM_TAGS(NUM_TAGS)) u_owner_table (
      .clk       (clk),
      .reset_n   (reset_n),
      .set_en    (set_en_s),
      .set_tag   (mem2proc_response),
      .set_owner (grant_owner_s),
      .ret_tag   (mem2proc_tag),
      .ret_hit   (ret_hit_s),
      .ret_owner (ret_owner_s),
      .orphan    (orphan_s)
   );

   assign icache_tag   = (ret_hit_s && (ret_owner_s == REQ_ICACHE)) ? mem2proc_tag : NO_TAG;
   assign dcache_tag   = (ret_hit_s && (ret_owner_s == REQ_DCACHE)) ? mem2proc_tag : NO_TAG;
   assign orphan_tag   = orphan_s & reset_n;
   assign mem_data_out = mem2proc_data;

`ifdef MEM_ARB_STATS_EN
   // Accepted-command and lock-occupancy counters, wrapping modulo 2^32
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         icache_grant_cnt <= 32'd0;
         dcache_grant_cnt <= 32'd0;
         lock_cycle_cnt   <= 32'd0;
      end else begin
         if (accepted_s && (grant_owner_s == REQ_ICACHE)) begin
            icache_grant_cnt <= icache_grant_cnt + 32'd1;
         end
         if (accepted_s && (grant_owner_s == REQ_DCACHE)) begin
            dcache_grant_cnt <= dcache_grant_cnt + 32'd1;
         end
         if (state_r != ARB_IDLE) begin
            lock_cycle_cnt <= lock_cycle_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
`ifndef XLEN
`define XLEN 64
`endif

module tb_mem_bus_arbiter;
   import mem_arb_pkg::*;

   localparam int SMAX = 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        icache_command, dcache_command;
   logic [`XLEN-1:0]  icache_addr, dcache_addr;
   logic [63:0]       dcache_data;
   logic [3:0]        icache_response, dcache_response, icache_tag, dcache_tag;
   logic [63:0]       mem_data_out;
   logic [1:0]        proc2mem_command;
   logic [`XLEN-1:0]  proc2mem_addr;
   logic [63:0]       proc2mem_data;
   logic [3:0]        mem2proc_response, mem2proc_tag;
   logic [63:0]       mem2proc_data;
   logic              orphan_tag;
`ifdef MEM_ARB_STATS_EN
   logic [31:0]       icache_grant_cnt, dcache_grant_cnt, lock_cycle_cnt;
`endif

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .icache_command(icache_command), .icache_addr(icache_addr),
      .dcache_command(dcache_command), .dcache_addr(dcache_addr), .dcache_data(dcache_data),
      .icache_response(icache_response), .dcache_response(dcache_response),
      .icache_tag(icache_tag), .dcache_tag(dcache_tag), .mem_data_out(mem_data_out),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
      .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag), .orphan_tag(orphan_tag)
`ifdef MEM_ARB_STATS_EN
      , .icache_grant_cnt(icache_grant_cnt), .dcache_grant_cnt(dcache_grant_cnt),
      .lock_cycle_cnt(lock_cycle_cnt)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [1:0] ic, input logic [`XLEN-1:0] ia,
                         input logic [1:0] dc, input logic [`XLEN-1:0] da,
                         input logic [63:0] dd, input logic [3:0] resp, input logic [3:0] rt);
      icache_command    = ic;
      icache_addr       = ia;
      dcache_command    = dc;
      dcache_addr       = da;
      dcache_data       = dd;
      mem2proc_response = resp;
      mem2proc_tag      = rt;
      mem2proc_data     = {$urandom, $urandom};
   endtask

   task automatic do_reset;
      set_in(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd0);
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      set_in(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd0);
      reset_n = 1'b0;
      @(negedge clk);
      tests++; if (proc2mem_command !== 2'd0 || proc2mem_addr !== '0 || proc2mem_data !== 64'd0) begin
         failed++; $display("FAIL reset_fwd got cmd=%0d addr=%h data=%h exp all zero", proc2mem_command, proc2mem_addr, proc2mem_data);
      end
      tests++; if ({icache_response, dcache_response, icache_tag, dcache_tag, orphan_tag} !== 17'd0) begin
         failed++; $display("FAIL reset_outs got ir=%0d dr=%0d it=%0d dt=%0d orph=%0d exp all zero", icache_response, dcache_response, icache_tag, dcache_tag, orphan_tag);
      end
      tests++; if (mem_data_out !== mem2proc_data) begin
         failed++; $display("FAIL reset_memdata got %h exp %h", mem_data_out, mem2proc_data);
      end
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_basic_grant;
      logic [`XLEN-1:0] ia, da;
      ia = `XLEN'(64'h1000); da = `XLEN'(64'h2008);
      do_reset();
      set_in(BUS_LOAD, ia, BUS_LOAD, da, 64'd0, 4'd3, 4'd0);
      @(negedge clk);
      tests++; if (dcache_response !== 4'd3 || icache_response !== 4'd0) begin
         failed++; $display("FAIL basic_resp got d=%0d i=%0d exp d=3 i=0", dcache_response, icache_response);
      end
      tests++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== da) begin
         failed++; $display("FAIL basic_fwd got cmd=%0d addr=%h exp cmd=1 addr=%h", proc2mem_command, proc2mem_addr, da);
      end
      tick();
      set_in(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd3);
      @(negedge clk);
      tests++; if (dcache_tag !== 4'd3 || icache_tag !== 4'd0 || orphan_tag !== 1'b0) begin
         failed++; $display("FAIL basic_ret got dt=%0d it=%0d orph=%0d exp dt=3 it=0 orph=0", dcache_tag, icache_tag, orphan_tag);
      end
      tick();
      set_in(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd3);
      @(negedge clk);
      tests++; if (orphan_tag !== 1'b1 || dcache_tag !== 4'd0) begin
         failed++; $display("FAIL basic_reret got orph=%0d dt=%0d exp orph=1 dt=0", orphan_tag, dcache_tag);
      end
      tick();
   endtask

   task automatic test_starvation;
      logic [`XLEN-1:0] ia, da;
      ia = `XLEN'(64'h40); da = `XLEN'(64'h80);
      do_reset();
      for (int c = 1; c <= SMAX; c++) begin
         set_in(BUS_LOAD, ia, BUS_LOAD, da, 64'd5, 4'd1, 4'd0);
         @(negedge clk);
         tests++; if (dcache_response !== 4'd1 || icache_response !== 4'd0) begin
            failed++; $display("FAIL starve_deny c=%0d got d=%0d i=%0d exp d=1 i=0", c, dcache_response, icache_response);
         end
         tick();
      end
      set_in(BUS_LOAD, ia, BUS_LOAD, da, 64'd5, 4'd1, 4'd0);
      @(negedge clk);
      tests++; if (icache_response !== 4'd1 || dcache_response !== 4'd0 || proc2mem_addr !== ia) begin
         failed++; $display("FAIL starve_win got i=%0d d=%0d addr=%h exp i=1 d=0 addr=%h", icache_response, dcache_response, proc2mem_addr, ia);
      end
      tick();
      set_in(BUS_LOAD, ia, BUS_LOAD, da, 64'd5, 4'd1, 4'd0);
      @(negedge clk);
      tests++; if (dcache_response !== 4'd1 || icache_response !== 4'd0) begin
         failed++; $display("FAIL starve_clear got d=%0d i=%0d exp d=1 i=0", dcache_response, icache_response);
      end
      tick();
   endtask

   task automatic test_lock;
      logic [`XLEN-1:0] ia, da;
      ia = `XLEN'(64'h300); da = `XLEN'(64'h500);
      do_reset();
      set_in(BUS_LOAD, ia, BUS_NONE, '0, 64'd0, 4'd0, 4'd0);
      @(negedge clk);
      tests++; if (proc2mem_addr !== ia || icache_response !== 4'd0) begin
         failed++; $display("FAIL lock_first got addr=%h i=%0d exp addr=%h i=0", proc2mem_addr, icache_response, ia);
      end
      tick();
      set_in(BUS_LOAD, ia, BUS_LOAD, da, 64'd9, 4'd0, 4'd0);
      @(negedge clk);
      tests++; if (proc2mem_addr !== ia || dcache_response !== 4'd0) begin
         failed++; $display("FAIL lock_hold got addr=%h d=%0d exp addr=%h d=0", proc2mem_addr, dcache_response, ia);
      end
      tick();
      set_in(BUS_LOAD, ia, BUS_LOAD, da, 64'd9, 4'd5, 4'd0);
      @(negedge clk);
      tests++; if (icache_response !== 4'd5 || dcache_response !== 4'd0) begin
         failed++; $display("FAIL lock_accept got i=%0d d=%0d exp i=5 d=0", icache_response, dcache_response);
      end
      tick();
      set_in(BUS_LOAD, ia, BUS_LOAD, da, 64'd9, 4'd6, 4'd0);
      @(negedge clk);
      tests++; if (dcache_response !== 4'd6 || proc2mem_addr !== da || proc2mem_data !== 64'd9) begin
         failed++; $display("FAIL lock_release got d=%0d addr=%h data=%h exp d=6 addr=%h data=9", dcache_response, proc2mem_addr, proc2mem_data, da);
      end
      tick();
   endtask

   task automatic test_store_orphan;
      logic [63:0] sd;
      sd = 64'hCAFE_F00D_1234_5678;
      do_reset();
      set_in(BUS_NONE, '0, BUS_STORE, `XLEN'(64'h88), sd, 4'd7, 4'd0);
      @(negedge clk);
      tests++; if (proc2mem_command !== BUS_STORE || proc2mem_data !== sd || dcache_response !== 4'd7) begin
         failed++; $display("FAIL store_fwd got cmd=%0d data=%h d=%0d exp cmd=2 data=%h d=7", proc2mem_command, proc2mem_data, dcache_response, sd);
      end
      tick();
      set_in(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd7);
      @(negedge clk);
      tests++; if (orphan_tag !== 1'b1 || icache_tag !== 4'd0 || dcache_tag !== 4'd0) begin
         failed++; $display("FAIL store_orphan got orph=%0d it=%0d dt=%0d exp orph=1 it=0 dt=0", orphan_tag, icache_tag, dcache_tag);
      end
      tick();
   endtask

   task automatic test_same_cycle_tag;
      do_reset();
      set_in(BUS_LOAD, `XLEN'(64'h10), BUS_NONE, '0, 64'd0, 4'd2, 4'd0);
      @(negedge clk);
      tests++; if (icache_response !== 4'd2) begin
         failed++; $display("FAIL same_alloc got i=%0d exp 2", icache_response);
      end
      tick();
      set_in(BUS_NONE, '0, BUS_LOAD, `XLEN'(64'h20), 64'd0, 4'd2, 4'd2);
      @(negedge clk);
      tests++; if (icache_tag !== 4'd2 || dcache_tag !== 4'd0 || dcache_response !== 4'd2) begin
         failed++; $display("FAIL same_cycle got it=%0d dt=%0d d=%0d exp it=2 dt=0 d=2", icache_tag, dcache_tag, dcache_response);
      end
      tick();
      set_in(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd2);
      @(negedge clk);
      tests++; if (dcache_tag !== 4'd2 || icache_tag !== 4'd0 || orphan_tag !== 1'b0) begin
         failed++; $display("FAIL same_later got dt=%0d it=%0d orph=%0d exp dt=2 it=0 orph=0", dcache_tag, icache_tag, orphan_tag);
      end
      tick();
   endtask

   task automatic test_reset_mid;
      do_reset();
      set_in(BUS_LOAD, `XLEN'(64'h10), BUS_NONE, '0, 64'd0, 4'd1, 4'd0);
      tick();
      set_in(BUS_NONE, '0, BUS_LOAD, `XLEN'(64'h20), 64'd0, 4'd4, 4'd0);
      tick();
      set_in(BUS_LOAD, `XLEN'(64'h30), BUS_NONE, '0, 64'd0, 4'd0, 4'd0);
      tick();
      set_in(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      set_in(BUS_LOAD, `XLEN'(64'h30), BUS_LOAD, `XLEN'(64'h40), 64'd0, 4'd9, 4'd0);
      @(negedge clk);
      tests++; if (dcache_response !== 4'd9 || icache_response !== 4'd0) begin
         failed++; $display("FAIL rstmid_idle got d=%0d i=%0d exp d=9 i=0", dcache_response, icache_response);
      end
      tick();
      set_in(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd1);
      @(negedge clk);
      tests++; if (orphan_tag !== 1'b1 || icache_tag !== 4'd0) begin
         failed++; $display("FAIL rstmid_tag1 got orph=%0d it=%0d exp orph=1 it=0", orphan_tag, icache_tag);
      end
      tick();
      set_in(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd4);
      @(negedge clk);
      tests++; if (orphan_tag !== 1'b1 || dcache_tag !== 4'd0) begin
         failed++; $display("FAIL rstmid_tag4 got orph=%0d dt=%0d exp orph=1 dt=0", orphan_tag, dcache_tag);
      end
      tick();
   endtask

   // Reference model: owner per tag (0 none, 1 icache, 2 dcache), refused requester, starvation count
   task automatic test_random;
      int own [16];
      int lockw, starve, who, n;
      logic [1:0] ic, dc, ecmd;
      logic [`XLEN-1:0] ia, da, eaddr;
      logic [63:0] dd, edata;
      logic [3:0] resp, rt, eir, edr, eit, edt;
      logic eorph, icr, dcr;
      for (int k = 0; k < 16; k++) own[k] = 0;
      lockw = 0; starve = 0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         ic = ($urandom_range(0, 9) < 6) ? BUS_LOAD : BUS_NONE;
         n  = $urandom_range(0, 9);
         dc = (n < 2) ? BUS_NONE : ((n < 6) ? BUS_LOAD : BUS_STORE);
         ia = `XLEN'({$urandom, $urandom} & 64'hFFFF_FFF8);
         da = `XLEN'({$urandom, $urandom});
         dd = {$urandom, $urandom};
         resp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         rt   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         set_in(ic, ia, dc, da, dd, resp, rt);
         icr = (ic != BUS_NONE); dcr = (dc != BUS_NONE);
         if (lockw == 1 && icr) who = 1;
         else if (lockw == 2 && dcr) who = 2;
         else if (icr && starve >= SMAX) who = 1;
         else if (dcr) who = 2;
         else if (icr) who = 1;
         else who = 0;
         ecmd  = (who == 1) ? ic : ((who == 2) ? dc : BUS_NONE);
         eaddr = (who == 1) ? ia : ((who == 2) ? da : '0);
         edata = (who == 2) ? dd : 64'd0;
         eir   = (who == 1) ? resp : 4'd0;
         edr   = (who == 2) ? resp : 4'd0;
         eit   = (rt != 4'd0 && own[rt] == 1) ? rt : 4'd0;
         edt   = (rt != 4'd0 && own[rt] == 2) ? rt : 4'd0;
         eorph = (rt != 4'd0 && own[rt] == 0);
         @(negedge clk);
         tests++;
         if ({proc2mem_command, proc2mem_addr, proc2mem_data, icache_response, dcache_response, icache_tag, dcache_tag, orphan_tag, mem_data_out}
             !== {ecmd, eaddr, edata, eir, edr, eit, edt, eorph, mem2proc_data}) begin
            failed++;
            $display("FAIL rand c=%0d got cmd=%0d addr=%h data=%h ir=%0d dr=%0d it=%0d dt=%0d orph=%0d exp cmd=%0d addr=%h data=%h ir=%0d dr=%0d it=%0d dt=%0d orph=%0d",
                     c, proc2mem_command, proc2mem_addr, proc2mem_data, icache_response, dcache_response, icache_tag, dcache_tag, orphan_tag,
                     ecmd, eaddr, edata, eir, edr, eit, edt, eorph);
         end
         lockw  = (who != 0 && resp == 4'd0) ? who : 0;
         starve = (icr && who != 1) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
         if (rt != 4'd0) own[rt] = 0;
         if (who != 0 && resp != 4'd0 && ecmd == BUS_LOAD) own[resp] = who;
         tick();
      end
   endtask

   initial begin
      reset_n = 1'b0;
      set_in(BUS_NONE, '0, BUS_NONE, '0, 64'd0, 4'd0, 4'd0);
      tick();
      test_reset();
      test_basic_grant();
      test_starvation();
      test_lock();
      test_store_orphan();
      test_same_cycle_tag();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
